// File: rtl/uart_pkg.sv
// Shared UART constants used by the receiver, transmitter and their buffers.
// Pure declarations: no logic, no latency.
// Imported by any block that needs to agree on the UART byte width.
package uart_pkg;

  // Width of one UART character as delivered by the receiver.
  localparam int UART_DATA_W = 8;

  // Pointer width for a FIFO of the given depth: index bits plus one wrap bit.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// Byte storage for the UART receive FIFO: one synchronous write port, one async read port.
// Latency: write lands at the clock edge; read data follows raddr combinationally.
// Backpressure: none here; the owning FIFO decides when we is asserted.
module uart_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  // Contents are deliberately not reset; out_data is meaningless until the first push.
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write the incoming byte into the addressed slot.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Head byte is read straight out of the array so the FIFO is first-word-fall-through.
  assign rdata = mem_q[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO (FWFT): captures in_valid strobes, hands bytes out over valid/ready.
// Latency: a byte pushed at edge k is presented on out_data/out_valid in the cycle after k.
// Backpressure: none upstream; when full with no pop, the byte is dropped (overrun flag when
// UART_RX_FIFO_OVERRUN_EN is defined, otherwise silently with overrun tied low).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   overrun,
  input  logic                   overrun_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = fifo_ptr_w(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic empty;
  logic pop;
  logic push;
  logic drop;

  // Status is decoded from registered pointers only.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign level = wr_ptr_q - rd_ptr_q;

  assign out_valid = !empty;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a byte
  // when the consumer is taking one; an empty FIFO never pops, so no bypass exists.
  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  // Next-state pointers: each advances by one on its own handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  // Pointer registers; reset empties the FIFO and discards any buffered bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (out_data)
  );

`ifdef UART_RX_FIFO_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Sticky loss flag: a drop in the same cycle as a clear leaves it set.
  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr) begin
      overrun_d = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end
  end

  // Overrun register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  // Without the flag, drops still happen when full but are not reported.
  logic unused_overrun;
  assign unused_overrun = overrun_clr ^ drop;
  assign overrun        = 1'b0;
`endif

endmodule : uart_rx_fifo
